// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between the calculator datapath and the
// BCD converter feeding the seven-segment decoders.
interface bin2bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  signed_mode;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  overflow;
    logic                  busy;
    logic                  done;

    modport master (
        output start, bin, signed_mode,
        input  bcd, neg, overflow, busy, done
    );

    modport slave (
        input  start, bin, signed_mode,
        output bcd, neg, overflow, busy, done
    );
endinterface

// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Outputs hold the last completed result; they only change on the done edge.
module bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    bin2bcd_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  sreg, mag;
    logic [BW-1:0]     work, adj, work_nxt;
    logic [CW-1:0]     cnt;
    logic              neg_cap, ovf_sticky, ovf_nxt, accept, last;
    logic [BW-1:0]     bcd_q;
    logic              neg_q, ovf_q, done_q;

    // Two's-complement negate stays WIDTH bits wide, so the most negative
    // value lands on 2^(WIDTH-1) as an unsigned magnitude.
    assign mag    = (bus.signed_mode && bus.bin[WIDTH-1]) ? (~bus.bin + WIDTH'(1)) : bus.bin;
    assign accept = (state == IDLE) && bus.start;
    assign last   = (state == SHIFT) && (cnt == CW'(1));

    always_comb begin
        adj = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
        end
    end

    // The bit pushed out of the top digit means the magnitude needs more digits.
    assign work_nxt = {adj[BW-2:0], sreg[WIDTH-1]};
    assign ovf_nxt  = ovf_sticky | adj[BW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg       <= '0;
            work       <= '0;
            cnt        <= '0;
            neg_cap    <= 1'b0;
            ovf_sticky <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                sreg       <= mag;
                neg_cap    <= bus.signed_mode & bus.bin[WIDTH-1];
                work       <= '0;
                ovf_sticky <= 1'b0;
                cnt        <= CW'(WIDTH);
            end else if (state == SHIFT) begin
                sreg       <= {sreg[WIDTH-2:0], 1'b0};
                work       <= work_nxt;
                ovf_sticky <= ovf_nxt;
                cnt        <= cnt - CW'(1);
            end
            if (last) begin
                bcd_q <= work_nxt;
                neg_q <= neg_cap;
                ovf_q <= ovf_nxt;
            end
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.neg      = neg_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state == SHIFT);
endmodule

// File: tb/tb_bin2bcd.sv
// Directed-vector bench for bin2bcd: a 5-digit instance for the main cases and
// a 4-digit instance for the overflow cases.
module tb_bin2bcd;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bin2bcd_if #(.WIDTH(16), .DIGITS(5)) b5 ();
    bin2bcd_if #(.WIDTH(16), .DIGITS(4)) b4 ();

    bin2bcd #(.WIDTH(16), .DIGITS(5)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(b5.slave));
    bin2bcd #(.WIDTH(16), .DIGITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    // Issue one start to the 5-digit unit and return cycles from accept to done (-1 on timeout).
    task automatic conv5(input logic [15:0] b, input logic sm, output int lat);
        @(negedge clk);
        b5.start = 1'b1; b5.bin = b; b5.signed_mode = sm;
        @(posedge clk); #1;
        b5.start = 1'b0;
        lat = 0;
        while (b5.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (b5.done !== 1'b1) lat = -1;
    endtask

    task automatic conv4(input logic [15:0] b, output int lat);
        @(negedge clk);
        b4.start = 1'b1; b4.bin = b; b4.signed_mode = 1'b0;
        @(posedge clk); #1;
        b4.start = 1'b0;
        lat = 0;
        while (b4.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (b4.done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        int lat;
        #1;
        n_checks++; if (b5.bcd !== 20'h0) begin n_fail++; $display("FAIL reset_bcd: got %h want 00000", b5.bcd); end
        n_checks++; if ({b5.neg, b5.overflow, b5.busy, b5.done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {b5.neg, b5.overflow, b5.busy, b5.done}); end
        @(negedge clk); rst_n = 1'b1;
        conv5(16'd300, 1'b1, lat);
        n_checks++; if (b5.bcd !== 20'h00300) begin n_fail++; $display("FAIL pre_reset_bcd: got %h want 00300", b5.bcd); end
        // Abort a conversion mid-flight
        @(negedge clk);
        b5.start = 1'b1; b5.bin = 16'd12345; b5.signed_mode = 1'b0;
        @(posedge clk); #1; b5.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (b5.bcd !== 20'h0) begin n_fail++; $display("FAIL midconv_reset_bcd: got %h want 00000", b5.bcd); end
        n_checks++; if ({b5.busy, b5.done, b5.neg, b5.overflow} !== 4'b0) begin n_fail++; $display("FAIL midconv_reset_flags: got %b want 0000", {b5.busy, b5.done, b5.neg, b5.overflow}); end
        @(negedge clk); rst_n = 1'b1;
        conv5(16'd0, 1'b0, lat);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 16", lat); end
        n_checks++; if ({b5.bcd, b5.neg, b5.overflow} !== {20'h00000, 2'b00}) begin n_fail++; $display("FAIL post_reset_zero: got %h %b%b want 00000 00", b5.bcd, b5.neg, b5.overflow); end
    endtask

    task automatic test_unsigned_max;
        int lat;
        conv5(16'd65535, 1'b0, lat);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL umax_latency: got %0d want 16", lat); end
        n_checks++; if (b5.bcd !== 20'h65535) begin n_fail++; $display("FAIL umax_bcd: got %h want 65535", b5.bcd); end
        n_checks++; if ({b5.neg, b5.overflow, b5.busy} !== 3'b000) begin n_fail++; $display("FAIL umax_flags: got %b want 000", {b5.neg, b5.overflow, b5.busy}); end
    endtask

    task automatic test_signed;
        int lat;
        logic [15:0] vin [4] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000};
        logic        vsm [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [19:0] vexp[4] = '{20'h00001, 20'h32768, 20'h32767, 20'h32768};
        logic        vneg[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            conv5(vin[i], vsm[i], lat);
            n_checks++; if (b5.bcd !== vexp[i]) begin n_fail++; $display("FAIL signed_bcd[%0d]: got %h want %h", i, b5.bcd, vexp[i]); end
            n_checks++; if ({b5.neg, b5.overflow} !== {vneg[i], 1'b0}) begin n_fail++; $display("FAIL signed_flags[%0d]: got %b%b want %b0", i, b5.neg, b5.overflow, vneg[i]); end
        end
    endtask

    task automatic test_overflow;
        int lat;
        logic [15:0] vin [4] = '{16'd12345, 16'd9999, 16'd10000, 16'd65535};
        logic [15:0] vexp[4] = '{16'h2345, 16'h9999, 16'h0000, 16'h5535};
        logic        vovf[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            conv4(vin[i], lat);
            n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL ovf_latency[%0d]: got %0d want 16", i, lat); end
            n_checks++; if (b4.bcd !== vexp[i]) begin n_fail++; $display("FAIL ovf_bcd[%0d]: got %h want %h", i, b4.bcd, vexp[i]); end
            n_checks++; if ({b4.overflow, b4.neg} !== {vovf[i], 1'b0}) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b%b want %b0", i, b4.overflow, b4.neg, vovf[i]); end
        end
    endtask

    task automatic test_busy_ignore;
        int cyc = 0, nd = 0, first = -1;
        @(negedge clk);
        b5.start = 1'b1; b5.bin = 16'd100; b5.signed_mode = 1'b0;
        @(posedge clk); #1; b5.start = 1'b0;
        n_checks++; if (b5.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b want 1", b5.busy); end
        repeat (3) begin @(posedge clk); cyc++; end
        @(negedge clk); b5.start = 1'b1; b5.bin = 16'd200;
        @(posedge clk); #1; cyc++; b5.start = 1'b0;
        while (cyc < 45) begin
            @(posedge clk); #1; cyc++;
            if (b5.done === 1'b1) begin nd++; if (first < 0) first = cyc; end
        end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
        n_checks++; if (first !== 16) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 16", first); end
        n_checks++; if (b5.bcd !== 20'h00100) begin n_fail++; $display("FAIL ignore_bcd: got %h want 00100", b5.bcd); end
    endtask

    task automatic test_back_to_back;
        int cyc = 0, nd = 0;
        int t[2] = '{-1, -1};
        @(negedge clk);
        b5.start = 1'b1; b5.bin = 16'd42; b5.signed_mode = 1'b0;
        @(posedge clk); #1;
        while (cyc < 50) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 17) begin
                b5.start = 1'b0;
                n_checks++; if (b5.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_restart: got %b want 1", b5.busy); end
            end
            if (b5.done === 1'b1) begin
                if (nd < 2) t[nd] = cyc;
                nd++;
                n_checks++; if (b5.bcd !== 20'h00042) begin n_fail++; $display("FAIL b2b_bcd: got %h want 00042", b5.bcd); end
            end
        end
        b5.start = 1'b0;
        n_checks++; if (nd !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
        n_checks++; if (t[0] !== 16 || t[1] !== 33) begin n_fail++; $display("FAIL b2b_done_cycles: got %0d,%0d want 16,33", t[0], t[1]); end
    endtask

    task automatic test_hold;
        int lat, cyc = 0;
        conv5(16'd65535, 1'b0, lat);
        @(negedge clk);
        b5.start = 1'b1; b5.bin = 16'd7; b5.signed_mode = 1'b0;
        @(posedge clk); #1; b5.start = 1'b0;
        while (b5.done !== 1'b1 && cyc < 40) begin
            n_checks++; if (b5.bcd !== 20'h65535) begin n_fail++; $display("FAIL hold_bcd cycle %0d: got %h want 65535", cyc, b5.bcd); end
            @(posedge clk); #1; cyc++;
        end
        n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL hold_latency: got %0d want 16", cyc); end
        n_checks++; if (b5.bcd !== 20'h00007) begin n_fail++; $display("FAIL hold_final_bcd: got %h want 00007", b5.bcd); end
        @(posedge clk); #1;
        n_checks++; if (b5.done !== 1'b0) begin n_fail++; $display("FAIL done_single_cycle: got %b want 0", b5.done); end
    endtask

    initial begin
        rst_n = 1'b0;
        b5.start = 1'b0; b5.bin = '0; b5.signed_mode = 1'b0;
        b4.start = 1'b0; b4.bin = '0; b4.signed_mode = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
